// File: rtl/ca_sample_capture.sv
// Sample capture buffer: records signed samples into a RAM, tracks peak max/min, registered readback.
// Latency: peaks and wr_count update the cycle after each write; readback data one cycle after rd_en.
// No backpressure: one sample accepted per sample_valid; samples outside a capture are dropped.
// Optional build macro CA_ZERO_CROSS_TRIG_EN: arm waits for a negative-to-non-negative crossing before capturing.
module ca_sample_capture #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic [DATA_W-1:0] peak_max,
  output logic [DATA_W-1:0] peak_min,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TRIG, S_CAPTURE, S_DONE} state_t;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH-1);

  state_t            state;
  logic              wr_en;
  logic [DATA_W-1:0] mem [DEPTH];

`ifdef CA_ZERO_CROSS_TRIG_EN
  logic [DATA_W-1:0] prev;
  logic              prev_vld;
  logic              trig_hit;

  // Crossing: previous valid sample negative, current sample non-negative.
  assign trig_hit = prev_vld && prev[DATA_W-1] && !sample_in[DATA_W-1];
`endif

  // A sample is stored while capturing, or when it is the sample that fires the trigger.
  always_comb begin
    wr_en = 1'b0;
    if (state == S_CAPTURE && sample_valid) begin
      wr_en = 1'b1;
    end
`ifdef CA_ZERO_CROSS_TRIG_EN
    if (state == S_WAIT_TRIG && sample_valid && trig_hit) begin
      wr_en = 1'b1;
    end
`endif
  end

  // Capture FSM with registered status, count and running peaks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_count <= '0;
      peak_max <= '0;
      peak_min <= '0;
`ifdef CA_ZERO_CROSS_TRIG_EN
      prev     <= '0;
      prev_vld <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            wr_count <= '0;
            peak_max <= MOST_NEG;
            peak_min <= MOST_POS;
            done     <= 1'b0;
            busy     <= 1'b1;
`ifdef CA_ZERO_CROSS_TRIG_EN
            prev     <= '0;
            prev_vld <= 1'b0;
            state    <= S_WAIT_TRIG;
`else
            state    <= S_CAPTURE;
`endif
          end
        end
        S_WAIT_TRIG: begin
`ifdef CA_ZERO_CROSS_TRIG_EN
          if (sample_valid) begin
            prev     <= sample_in;
            prev_vld <= 1'b1;
            if (trig_hit) begin
              state <= S_CAPTURE;
            end
          end
`endif
        end
        default: ;
      endcase

      // Shared write path; the write filling the last slot closes the capture.
      if (wr_en) begin
        wr_count <= wr_count + (ADDR_W+1)'(1);
        if ($signed(sample_in) > $signed(peak_max)) peak_max <= sample_in;
        if ($signed(sample_in) < $signed(peak_min)) peak_min <= sample_in;
        if (wr_count == LAST_IDX) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_count[ADDR_W-1:0]] <= sample_in;
    end
  end

  // Registered read port; a same-address write in the same cycle returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[rd_addr];
      end
    end
  end

endmodule

// File: tb/tb_ca_sample_capture.sv
module tb_ca_sample_capture;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int AW = 3;
`ifdef CA_ZERO_CROSS_TRIG_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, arm, sample_valid, rd_en;
  logic [DW-1:0] sample_in;
  logic [AW-1:0] rd_addr;
  logic          busy, done, rd_valid;
  logic [AW:0]   wr_count;
  logic [DW-1:0] peak_max, peak_min, rd_data;

  ca_sample_capture #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .sample_in(sample_in), .sample_valid(sample_valid),
    .busy(busy), .done(done), .wr_count(wr_count), .peak_max(peak_max), .peak_min(peak_min),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 done.
  int            phase = 0;
  int            cap_q[$];
  int            m_mem[D];
  int            prev;
  bit            prev_vld;
  bit            peaks_zero = 1'b1;
  logic          m_rd_valid;
  logic [DW-1:0] m_rd_data;

  function automatic int q_max();
    int m = 32'h8000_0000;
    foreach (cap_q[i]) if (cap_q[i] > m) m = cap_q[i];
    return peaks_zero ? 0 : m;
  endfunction

  function automatic int q_min();
    int m = 32'h7fff_ffff;
    foreach (cap_q[i]) if (cap_q[i] < m) m = cap_q[i];
    return peaks_zero ? 0 : m;
  endfunction

  function automatic void store(input int s);
    m_mem[cap_q.size()] = s;
    cap_q.push_back(s);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      cap_q.delete();
      peaks_zero = 1'b1;
      m_rd_valid = 1'b0;
      m_rd_data = '0;
    end else begin
      m_rd_valid = rd_en;
      if (rd_en) m_rd_data = m_mem[rd_addr];
      case (phase)
        0, 3: if (arm) begin
          cap_q.delete();
          peaks_zero = 1'b0;
          prev_vld = 1'b0;
          phase = TRIG ? 1 : 2;
        end
        1: if (sample_valid) begin
          if (prev_vld && prev < 0 && $signed(sample_in) >= 0) begin
            store(sample_in);
            phase = 2;
          end
          prev = sample_in;
          prev_vld = 1'b1;
        end
        2: if (sample_valid) begin
          store(sample_in);
          if (cap_q.size() == D) phase = 3;
        end
        default: ;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always begin
    @(posedge clk);
    #1;
    if (cmp_en) begin
      chk("busy", {31'b0, busy}, {31'b0, (phase == 1 || phase == 2)});
      chk("done", {31'b0, done}, {31'b0, (phase == 3)});
      chk("wr_count", {28'b0, wr_count}, cap_q.size());
      chk("peak_max", peak_max, q_max());
      chk("peak_min", peak_min, q_min());
      chk("rd_valid", {31'b0, rd_valid}, {31'b0, m_rd_valid});
      if (m_rd_valid) chk("rd_data", rd_data, m_rd_data);
    end
  end

  task automatic drive(input bit a, input bit v, input int s, input bit re, input int ra);
    @(negedge clk);
    arm = a;
    sample_valid = v;
    sample_in = s;
    rd_en = re;
    rd_addr = ra[AW-1:0];
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic read_chk(input string name, input int addr, input int exp);
    drive(0, 0, 0, 1, addr);
    idle();
    chk({name, "_vld"}, {31'b0, rd_valid}, 32'd1);
    chk(name, rd_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;
    rd_en = 1'b0;
    rd_addr = '0;
    idle();
    idle();
    cmp_en = 1'b1;
    idle();
    rst = 1'b0;
    idle();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wr_count", {28'b0, wr_count}, 32'd0);

`ifndef CA_ZERO_CROSS_TRIG_EN
    // Full capture of 1..8, then readback.
    drive(1, 0, 0, 0, 0);
    for (int i = 1; i <= D; i++) drive(0, 1, i, 0, 0);
    idle();
    chk("full_done", {31'b0, done}, 32'd1);
    chk("full_busy", {31'b0, busy}, 32'd0);
    chk("full_wr_count", {28'b0, wr_count}, 32'd8);
    chk("full_peak_max", peak_max, 32'd8);
    chk("full_peak_min", peak_min, 32'd1);
    for (int i = 0; i < D; i++) read_chk("full_rd", i, i + 1);

    // Reset held three cycles in the middle of a capture.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 10, 0, 0);
    drive(0, 1, 20, 0, 0);
    drive(0, 1, 30, 1, 1);
    rst = 1'b1;
    drive(0, 1, 40, 0, 0);
    drive(0, 1, 50, 0, 0);
    drive(0, 1, 60, 0, 0);
    rst = 1'b0;
    idle();
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_wr_count", {28'b0, wr_count}, 32'd0);
    chk("midrst_peak_max", peak_max, 32'd0);
    chk("midrst_peak_min", peak_min, 32'd0);
    chk("midrst_rd_valid", {31'b0, rd_valid}, 32'd0);

    // Alternating valid: only valid samples land; the 99s are dropped.
    drive(1, 0, 0, 0, 0);
    begin
      int vals[8] = '{-5, 3, 7, -2, 11, 4, 0, 6};
      foreach (vals[i]) begin
        drive(0, 1, vals[i], 0, 0);
        drive(0, 0, 99, 0, 0);
      end
    end
    chk("skip_done", {31'b0, done}, 32'd1);
    chk("skip_peak_min", peak_min, -5);
    chk("skip_peak_max", peak_max, 32'd11);
    read_chk("skip_rd0", 0, -5);
    read_chk("skip_rd1", 1, 3);

    // Arm during capture is ignored; arm in DONE restarts from mem[0].
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 100 + i, 0, 0);
    drive(1, 1, 103, 0, 0);
    idle();
    chk("rearm_ignored_wr_count", {28'b0, wr_count}, 32'd4);
    chk("rearm_ignored_busy", {31'b0, busy}, 32'd1);
    for (int i = 4; i < D; i++) drive(0, 1, 100 + i, 0, 0);
    idle();
    chk("rearm_done", {31'b0, done}, 32'd1);
    drive(1, 0, 0, 0, 0);
    idle();
    chk("rearm_wr_count", {28'b0, wr_count}, 32'd0);
    chk("rearm_done_clr", {31'b0, done}, 32'd0);
    drive(0, 1, 42, 1, 0);
    idle();
    chk("rbw_old_word", rd_data, 32'd100);
    chk("rbw_wr_count", {28'b0, wr_count}, 32'd1);
    read_chk("rbw_new_word", 0, 42);
`else
    // Zero-cross trigger: fires on 2 after -1.
    drive(1, 0, 0, 0, 0);
    begin
      int vals[6] = '{-3, -1, 2, 4, -2, 7};
      foreach (vals[i]) drive(0, 1, vals[i], 0, 0);
    end
    idle();
    chk("trig_wr_count", {28'b0, wr_count}, 32'd4);
    chk("trig_peak_max", peak_max, 32'd7);
    chk("trig_peak_min", peak_min, -2);
    chk("trig_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 0);
    idle();
    chk("trig_done", {31'b0, done}, 32'd1);
    read_chk("trig_rd0", 0, 2);
    read_chk("trig_rd1", 1, 4);
    read_chk("trig_rd2", 2, -2);
    read_chk("trig_rd3", 3, 7);

    // First sample after arm cannot trigger; 0 then 5 never crosses.
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 5, 0, 0);
    idle();
    chk("notrig_busy", {31'b0, busy}, 32'd1);
    chk("notrig_wr_count", {28'b0, wr_count}, 32'd0);
    chk("notrig_done", {31'b0, done}, 32'd0);
`endif

    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/ca_sample_capture.md
Name: ca_sample_capture

Overview:
- Receiving end of the ROM-driven AC source sample stream: records the 32-bit signed samples it emits (source voltage or computed current) into an on-chip buffer.
- Tracks peak max/min over each capture.
- Exposes a registered readback port so a host/UART bridge can dump a completed waveform.
- Sits beside the AC source on the same clk, consuming one sample per sample_valid strobe.

Parameters:
DATA_W, 32, sample width (two's-complement signed)
DEPTH, 1024, buffer depth in samples (power of two, >=4)
ADDR_W, 10, log2(DEPTH)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous reset, active-high
arm  input  1  one-cycle pulse: start a new capture
sample_in  input  DATA_W  signed sample from source
sample_valid  input  1  sample_in valid this cycle
busy  output  1  high in WAIT_TRIG or CAPTURE
done  output  1  high in DONE (buffer full, results stable)
wr_count  output  ADDR_W+1  samples stored in current capture
peak_max  output  DATA_W  signed max of stored samples
peak_min  output  DATA_W  signed min of stored samples
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
rd_data  output  DATA_W  buffer word, registered
rd_valid  output  1  rd_data valid (rd_en delayed one cycle)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On rst: state=IDLE; busy=0, done=0, wr_count=0, peak_max=0, peak_min=0, rd_data=0, rd_valid=0. Buffer RAM contents not cleared.
- FSM states: IDLE, WAIT_TRIG, CAPTURE, DONE.
- IDLE or DONE + arm=1:
  - wr_count<=0, peak_max<=most-negative, peak_min<=most-positive, done<=0.
  - Next state: WAIT_TRIG if trigger enabled, else CAPTURE.
- arm while in WAIT_TRIG or CAPTURE: ignored.
- CAPTURE: each cycle with sample_valid=1:
  - mem[wr_count]<=sample_in; wr_count<=wr_count+1.
  - peak_max/peak_min updated with signed compare including this sample; visible the next cycle.
  - The write that brings wr_count to DEPTH moves state to DONE in the same edge. done=1 and busy=0 from the following cycle.
  - Samples with sample_valid=0 are skipped; no write, no count.
- DONE: buffer frozen, wr_count=DEPTH, peaks held; all further samples ignored until arm.
- Readback:
  - rd_en=1 at edge N gives rd_data=mem[rd_addr] and rd_valid=1 after edge N+1 (latency 1). rd_valid=0 otherwise; rd_data holds its last value.
  - Reads allowed in any state.
  - Same-address read and write in one cycle returns the OLD word (read-before-write).
- rst mid-capture aborts the capture. Partial data stays in the RAM but wr_count reads 0.
- Arithmetic: all compares signed DATA_W. wr_count is unsigned ADDR_W+1 and never wraps; it saturates at DEPTH via the DONE transition.

Optional Feature:
- Macro: CA_ZERO_CROSS_TRIG_EN.
- Defined:
  - arm enters WAIT_TRIG. prev register is cleared and marked invalid.
  - Each valid sample updates prev and sets it valid.
  - Trigger fires on a valid sample where prev is valid, prev<0 and sample_in>=0. The triggering sample is written to mem[0] in the same cycle (counts as first capture sample, updates peaks), and state goes to CAPTURE.
  - The first valid sample after arm can never trigger.
- Undefined: WAIT_TRIG is unreachable; arm goes directly to CAPTURE, and the first valid sample after arm lands in mem[0].

Test Plan:
- rst held 3 cycles mid-stream -> busy=0, done=0, wr_count=0, peak_max=0, peak_min=0, rd_valid=0.
- DEPTH=8, no macro, arm then samples 1..8 with sample_valid every cycle -> done=1 one cycle after 8th write, wr_count=8, peak_max=8, peak_min=1. Reads of addr 0..7 return 1..8 with rd_valid one cycle after rd_en.
- DEPTH=8, sample_valid toggling 1,0,1,0 with values -5,99,3,99,... -> only valid samples stored. mem[0]=-5, mem[1]=3, peak_min=-5; the 99s never appear.
- CA_ZERO_CROSS_TRIG_EN, DEPTH=4, stream -3,-1,2,4,-2,7 after arm -> trigger on 2; mem = 2,4,-2,7; peak_max=7, peak_min=-2, done=1.
- CA_ZERO_CROSS_TRIG_EN, first sample after arm = 0 followed by 5 -> no trigger (prev invalid, then prev>=0); state stays WAIT_TRIG, busy=1.
- Second arm pulse during CAPTURE at wr_count=3 -> ignored, wr_count continues to 4. arm in DONE -> wr_count=0, done=0 next cycle, new capture overwrites from mem[0].
